// File: rtl/imm_ext_unit.sv
// imm_ext_unit: pipelined immediate-extension unit for the multicycle datapath.
// Builds a DATA_W-wide operand from the shamt / imm16 / jump-target fields of
// one instruction and hands it to the ALU-B and PC-target muxes through a
// 2-entry skid buffer with a valid/ready handshake.
// Optional build macro: EXT_ILLEGAL_TRAP_EN (modes 6/7 flag an error and
// latch a sticky trap that blocks further requests until Reset).
module imm_ext_unit #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        mode,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic [DATA_W-29:0] pc_hi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bufState_t;

    bufState_t state_p1;
    bufState_t stateNext;

    logic [DATA_W-1:0] slot0Data_p1;
    logic [DATA_W-1:0] slot1Data_p1;
    logic [DATA_W-1:0] extData;
    logic              acceptReq;
    logic              drainReq;

    // Operand construction for every mode; illegal modes produce zero.
    function automatic logic [DATA_W-1:0] extendImm(
        input logic [2:0]         m,
        input logic [4:0]         sa,
        input logic [15:0]        im,
        input logic [25:0]        tgt,
        input logic [DATA_W-29:0] pcHi
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (m)
            3'd0: r[4:0] = sa;
            3'd1: r[15:0] = im;
            3'd2: begin
                r       = {DATA_W{im[15]}};
                r[15:0] = im;
            end
            3'd3: begin
                // LUI result is a 32-bit value, sign-extended to the full width
                r       = {DATA_W{im[15]}};
                r[31:0] = {im, 16'h0000};
            end
            3'd4: begin
                r       = {DATA_W{im[15]}};
                r[17:0] = {im, 2'b00};
            end
            3'd5: r = {pcHi, tgt, 2'b00};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign extData   = extendImm(mode, shamt, imm, target, pc_hi);
    assign acceptReq = in_valid & in_ready;
    assign drainReq  = out_valid & out_ready;
    assign out_valid = (state_p1 != EMPTY);
    assign out_data  = slot0Data_p1;

`ifdef EXT_ILLEGAL_TRAP_EN
    logic slot0Err_p1;
    logic slot1Err_p1;
    logic trapSticky_p1;
    logic extErr;

    assign extErr   = mode[2] & mode[1];
    // Once an illegal mode has been accepted nothing more is taken in.
    assign in_ready = (state_p1 != TWO) && !trapSticky_p1;
    assign out_err  = slot0Err_p1;

    // Sticky trap: set by an accepted illegal request that flush did not discard.
    always_ff @(posedge CLK) begin
        if (Reset)
            trapSticky_p1 <= 1'b0;
        else if (!flush && acceptReq && extErr)
            trapSticky_p1 <= 1'b1;
    end

    // Error bit moves through the buffer in lockstep with its data word.
    always_ff @(posedge CLK) begin
        if (Reset || flush) begin
            slot0Err_p1 <= 1'b0;
            slot1Err_p1 <= 1'b0;
        end else begin
            case (state_p1)
                EMPTY: if (acceptReq) slot0Err_p1 <= extErr;
                ONE: begin
                    if (acceptReq && drainReq)
                        slot0Err_p1 <= extErr;
                    else if (acceptReq)
                        slot1Err_p1 <= extErr;
                end
                TWO: if (drainReq) slot0Err_p1 <= slot1Err_p1;
                default: ;
            endcase
        end
    end
`else
    // in_ready depends on registered state only, never on out_ready.
    assign in_ready = (state_p1 != TWO);
    assign out_err  = 1'b0;
`endif

    // ---- stage p1: buffer occupancy register
    always_ff @(posedge CLK) begin
        if (Reset)
            state_p1 <= EMPTY;
        else
            state_p1 <= stateNext;
    end

    // Next buffer occupancy from accept/drain; flush empties the buffer.
    always_comb begin
        stateNext = state_p1;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (state_p1)
                EMPTY: if (acceptReq) stateNext = ONE;
                ONE: begin
                    if (acceptReq && !drainReq)
                        stateNext = TWO;
                    else if (!acceptReq && drainReq)
                        stateNext = EMPTY;
                end
                TWO: if (drainReq) stateNext = ONE;
                default: stateNext = EMPTY;
            endcase
        end
    end

    // Buffer data: slot 0 feeds the outputs, slot 1 absorbs one stalled request.
    always_ff @(posedge CLK) begin
        if (Reset || flush) begin
            slot0Data_p1 <= '0;
            slot1Data_p1 <= '0;
        end else begin
            case (state_p1)
                EMPTY: if (acceptReq) slot0Data_p1 <= extData;
                ONE: begin
                    // accept+drain replaces the head directly, so no bubble
                    if (acceptReq && drainReq)
                        slot0Data_p1 <= extData;
                    else if (acceptReq)
                        slot1Data_p1 <= extData;
                end
                TWO: if (drainReq) slot0Data_p1 <= slot1Data_p1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed self-checking bench for imm_ext_unit (32-bit and 64-bit instances).
module tb_imm_ext_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mode;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [3:0]  pc_hi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    logic        inValid64;
    logic        inReady64;
    logic [2:0]  mode64;
    logic [15:0] imm64;
    logic [35:0] pcHi64;
    logic        outValid64;
    logic [63:0] outData64;
    logic        outErr64;

    int errors = 0;
    int checks = 0;

    imm_ext_unit #(.DATA_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .shamt(shamt), .imm(imm), .target(target), .pc_hi(pc_hi),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    imm_ext_unit #(.DATA_W(64)) dut64 (
        .CLK(CLK), .Reset(Reset), .flush(1'b0),
        .in_valid(inValid64), .in_ready(inReady64),
        .mode(mode64), .shamt(5'h00), .imm(imm64), .target(26'h0), .pc_hi(pcHi64),
        .out_valid(outValid64), .out_ready(1'b1),
        .out_data(outData64), .out_err(outErr64)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        checks++; if (outValid64 !== 1'b0) begin errors++; $display("FAIL reset_out_valid64 got=%b exp=0", outValid64); end
    endtask

    task automatic test_modes();
        logic [31:0] expData [6];
        expData[0] = 32'h0000001F;
        expData[1] = 32'h00008004;
        expData[2] = 32'hFFFF8004;
        expData[3] = 32'h80040000;
        expData[4] = 32'hFFFE0010;
        expData[5] = 32'hAFFFFFFC;
        out_ready = 1'b1;
        imm = 16'h8004; shamt = 5'h1F; target = 26'h3FFFFFF; pc_hi = 4'hA;
        for (int m = 0; m < 6; m++) begin
            mode = 3'(m);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got=%b exp=1", m, out_valid); end
            checks++; if (out_data !== expData[m]) begin errors++; $display("FAIL mode%0d_data got=%h exp=%h", m, out_data, expData[m]); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL mode%0d_err got=%b exp=0", m, out_err); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL modes_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_width64();
        mode64 = 3'd3; imm64 = 16'h8000; pcHi64 = 36'h0;
        inValid64 = 1'b1;
        tick();
        inValid64 = 1'b0;
        checks++; if (outValid64 !== 1'b1) begin errors++; $display("FAIL w64_valid got=%b exp=1", outValid64); end
        checks++; if (outData64 !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL w64_lui got=%h exp=ffffffff80000000", outData64); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        mode = 3'd1;
        in_valid = 1'b1;
        imm = 16'h0001;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got=%b exp=1", in_ready); end
        tick();
        imm = 16'h0002;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got=%b exp=1", in_ready); end
        tick();
        imm = 16'h0003;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL bp_hold got=%h exp=00000001", out_data); end
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_data !== 32'h2) begin errors++; $display("FAIL bp_second got=%h exp=00000002", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== 32'h3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got=%h/%b exp=00000003/1", out_data, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        mode = 3'd1;
        for (int i = 0; i < 8; i++) begin
            imm = 16'(16'h0010 + i);
            in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(16'h0010 + i)) begin
                errors++;
                $display("FAIL stream%0d got=%h/%b exp=%h/1", i, out_data, out_valid, 32'(16'h0010 + i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        mode = 3'd1;
        in_valid = 1'b1;
        imm = 16'h0055;
        tick();
        imm = 16'h0066;
        tick();
        imm = 16'h0077;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL flush_data got=%h exp=00000000", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_late%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        imm = 16'h1234;
        mode = 3'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0) begin errors++; $display("FAIL ill7_data got=%h/%b exp=00000000/1", out_data, out_valid); end
`ifdef EXT_ILLEGAL_TRAP_EN
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ill7_err got=%b exp=1", out_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_ready got=%b exp=0", in_ready); end
        mode = 3'd1;
        in_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL trap_blocked got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_sticky got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_sticky2 got=%b exp=0", in_ready); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL trap_reset got=%b/%b exp=1/0", in_ready, out_valid); end
        checks++; if (out_data !== 32'h0 || out_err !== 1'b0) begin errors++; $display("FAIL trap_reset_out got=%h/%b exp=00000000/0", out_data, out_err); end
`else
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL ill7_err got=%b exp=0", out_err); end
        mode = 3'd6;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_err !== 1'b0) begin errors++; $display("FAIL ill6 got=%h/%b/%b exp=00000000/1/0", out_data, out_valid, out_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
        tick();
`endif
    endtask

    initial begin
        Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 3'd0; shamt = 5'h0; imm = 16'h0; target = 26'h0; pc_hi = 4'h0;
        inValid64 = 1'b0; mode64 = 3'd0; imm64 = 16'h0; pcHi64 = 36'h0;
        #1;
        test_reset();
        test_modes();
        test_width64();
        test_backpressure();
        test_streaming();
        test_flush();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
